// File: rtl/reg_bank_arbiter.sv
// Shared config/status register bank with a two-port round-robin arbiter.
// Port A (SPI-side) and port B (local host) are serialised. Each access takes
// IDLE -> ACCESS -> DONE, and all outputs are registered.
module reg_bank_arbiter #(
  parameter int unsigned NUM_CFG   = 8,
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned ADDR_W    = $clog2(NUM_CFG) + 1,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           a_req,
  input  logic                           a_we,
  input  logic [ADDR_W-1:0]              a_addr,
  input  logic [REG_WIDTH-1:0]           a_wdata,
  output logic                           a_gnt,
  output logic [REG_WIDTH-1:0]           a_rdata,
  output logic                           a_err,
  input  logic                           b_req,
  input  logic                           b_we,
  input  logic [ADDR_W-1:0]              b_addr,
  input  logic [REG_WIDTH-1:0]           b_wdata,
  output logic                           b_gnt,
  output logic [REG_WIDTH-1:0]           b_rdata,
  output logic                           b_err,
  output logic [NUM_CFG*REG_WIDTH-1:0]   config_regs,
  input  logic [NUM_CFG*REG_WIDTH-1:0]   status_regs
);

  localparam int unsigned IdxW = ADDR_W - 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e state_q, state_d;

  // Latched winner request; sel/last_srv use 0 = port A, 1 = port B
  logic                 sel_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [REG_WIDTH-1:0] wdata_q;
  logic                 last_srv_q;

  logic [REG_WIDTH-1:0] cfg_q [NUM_CFG];
  logic [REG_WIDTH-1:0] status_arr [NUM_CFG];

  logic                 a_gnt_q, b_gnt_q, a_err_q, b_err_q;
  logic [REG_WIDTH-1:0] a_rdata_q, b_rdata_q;

  logic                 launch, pick_b, in_access, in_done, addr_is_status, wr_cfg;
  logic [IdxW-1:0]      idx;
  logic [REG_WIDTH-1:0] rd_val;

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_flat
    assign config_regs[i*REG_WIDTH +: REG_WIDTH] = cfg_q[i];
    assign status_arr[i]                         = status_regs[i*REG_WIDTH +: REG_WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one arbitration, one access cycle, one completion cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ena && (a_req || b_req)) state_d = StAccess;
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Decoded strobes for the datapath
  always_comb begin
    launch         = (state_q == StIdle) && ena && (a_req || b_req);
    // On contention B wins only if A was served last
    pick_b         = b_req && (!a_req || !last_srv_q);
    in_access      = (state_q == StAccess);
    in_done        = (state_q == StDone);
    addr_is_status = addr_q[ADDR_W-1];
    idx            = addr_q[IdxW-1:0];
    wr_cfg         = in_access && we_q && !addr_is_status;
    rd_val         = addr_is_status ? status_arr[idx] : cfg_q[idx];
  end

  // Request latch, register bank, round-robin pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_srv_q <= 1'b1;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_q[i] <= CFG_RESET[i*REG_WIDTH +: REG_WIDTH];
      end
    end else begin
      if (launch) begin
        sel_q   <= pick_b;
        we_q    <= pick_b ? b_we    : a_we;
        addr_q  <= pick_b ? b_addr  : a_addr;
        wdata_q <= pick_b ? b_wdata : a_wdata;
      end
      if (wr_cfg) begin
        cfg_q[idx] <= wdata_q;
      end
      if (in_access) begin
        last_srv_q <= sel_q;
        if (sel_q) begin
          b_gnt_q <= 1'b1;
          b_err_q <= we_q && addr_is_status;
          if (!we_q) b_rdata_q <= rd_val;
        end else begin
          a_gnt_q <= 1'b1;
          a_err_q <= we_q && addr_is_status;
          if (!we_q) a_rdata_q <= rd_val;
        end
      end
      if (in_done) begin
        a_gnt_q <= 1'b0;
        b_gnt_q <= 1'b0;
        a_err_q <= 1'b0;
        b_err_q <= 1'b0;
      end
    end
  end

  assign a_gnt   = a_gnt_q;
  assign b_gnt   = b_gnt_q;
  assign a_err   = a_err_q;
  assign b_err   = b_err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Owns the shared configuration/status register bank and arbitrates it between two requesters: port A (SPI-side register access) and port B (on-chip local host).
- Serialises accesses with round-robin fairness and drives the flattened config_regs bus that feeds the pad outputs.
- Returns read data from config storage or the status_regs input.

Parameters:
- NUM_CFG, 8, number of config registers; must be a power of two, ≥2; equals number of status registers.
- REG_WIDTH, 8, bits per register.
- ADDR_W, $clog2(NUM_CFG)+1, request address width; MSB selects the status bank.
- CFG_RESET, {NUM_CFG*REG_WIDTH{1'b0}}, reset image of config_regs.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  arbitration enable.
- a_req  in  1  port A access request.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  REG_WIDTH  port A write data.
- a_gnt  out  1  port A completion pulse.
- a_rdata  out  REG_WIDTH  port A read data.
- a_err  out  1  port A error (write to status), valid with a_gnt.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_err: same as port A, for port B.
- config_regs  out  NUM_CFG*REG_WIDTH  flattened config bank; reg i at [i*REG_WIDTH +: REG_WIDTH].
- status_regs  in  NUM_CFG*REG_WIDTH  flattened status bank, sampled on read.

Behaviour:
- Single clock domain; clk and rst only; rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - FSM = IDLE.
  - a_gnt, b_gnt, a_err, b_err = 0.
  - a_rdata, b_rdata = 0.
  - config_regs = CFG_RESET.
  - Round-robin pointer last_srv = B, so A wins the first contention.
- FSM:
  - IDLE: if ena and any req, pick the winner and go to ACCESS. Only one req → that port. Both → the port not equal to last_srv. Latch sel, we, addr, wdata from the winner.
  - ACCESS, one cycle:
    - Write with addr MSB=0: config reg addr[ADDR_W-2:0] <= wdata.
    - Write with addr MSB=1: no storage change; err <= 1.
    - Read: rdata_sel <= config or status reg per MSB; err <= 0.
    - gnt_sel <= 1; last_srv <= sel; go to DONE.
  - DONE: gnt_sel and err_sel high this cycle only; then return to IDLE, clearing gnt/err.
- Latency: req sampled at edge N → gnt high during cycle N+2 → next arbitration at edge N+3. Config write is visible on config_regs in the same cycle as gnt. Maximum throughput is one access per 3 cycles.
- Handshake:
  - Requester holds req, we, addr, wdata stable until gnt.
  - Requester must drop req the cycle after gnt unless it issues a new access.
  - req still high in IDLE is treated as a new request.
  - Losing port keeps req high and is served next; worst-case wait is one access (3 cycles).
- rdata holds its last value until the next read by the same port. A write does not change rdata.
- Non-selected port's gnt/err/rdata are unaffected by the other port's access.
- ena=0: no new grants from IDLE. A transaction already in ACCESS/DONE completes normally. Pending reqs stay pending.
- Read of a config reg returns its current stored value. Accesses are serialised, so there are no read/write collisions between ports.
- rst asserted in any state:
  - Next cycle the FSM is in IDLE and every output is at its reset value.
  - An in-flight write is aborted if rst is sampled at or before the ACCESS edge.
  - No gnt is issued for an aborted access.
- status_regs is sampled only at the ACCESS edge of a read.

Test Plan:
- Reset, then A writes addr 0 data 8'h3C → a_gnt 1-cycle pulse 2 cycles after req; config_regs[7:0]=8'h3C in the same cycle; a_err=0; b_gnt stays 0.
- B reads addr 4'b1000 with status_regs[7:0]=8'hCA → b_rdata=8'hCA with b_gnt; b_err=0; config_regs unchanged.
- A and B request simultaneously from reset (A writes reg1=8'h11, B writes reg2=8'h22), both holding req → A granted first, B granted 3 cycles later; next contention is granted to A again; final config_regs[23:8]=16'h2211.
- A writes 8'hFF to status addr 4'b1011 → a_gnt with a_err=1; config_regs unchanged; subsequent read of 4'b1011 returns status_regs[31:24].
- ena=0 with a_req high for 5 cycles → no a_gnt; raise ena → a_gnt 2 cycles after the ena edge. Deassert ena while in ACCESS → that access still completes.
- B write to reg3 with rst asserted during the ACCESS cycle → no b_gnt; config_regs=CFG_RESET; FSM in IDLE. Post-reset contention is granted to A first.
